// File: rtl/hls_call_pkg.sv
// Shared types and constants for the HLS call master and its busy timer.
package hls_call_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int CALL_CNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_START,
    S_BUSY,
    S_RSP
  } call_state_e;

  // Bits needed to hold max_val without wrapping (never less than one).
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/hls_call_timer.sv
// Clearable busy-cycle counter; tc flags the last busy cycle before abort.
module hls_call_timer
  import hls_call_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CNT_W = cnt_width(TIMEOUT_CYC);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // The abort fires on the edge that closes the TIMEOUT_CYC-th busy cycle.
  generate
    if (TIMEOUT_CYC > 0) begin : g_timeout
      assign tc = en && (cnt == CNT_W'(TIMEOUT_CYC - 1));
    end else begin : g_no_timeout
      assign tc = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/hls_call_master.sv
// Issues one call per upstream request to a start/done callee and returns
// the result (or a timeout abort) on a valid/ready response channel.
module hls_call_master
  import hls_call_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT_CYC = 1024,
  parameter int COUNT_W     = CALL_CNT_W
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [DATA_W-1:0]  req_a,
  input  logic [DATA_W-1:0]  req_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DATA_W-1:0]  rsp_data,
  output logic               rsp_timeout,
  output logic [DATA_W-1:0]  callee_a,
  output logic [DATA_W-1:0]  callee_b,
  output logic               callee_start,
  input  logic               callee_idle,
  input  logic               callee_done,
  input  logic [DATA_W-1:0]  callee_ret,
  output logic [COUNT_W-1:0] call_count
);

  call_state_e state, state_nxt;
  logic        tc;
  logic        accept;
  logic        done_hit;

  assign accept   = (state == S_IDLE) && req_valid;
  assign done_hit = (state == S_BUSY) && callee_done;

  hls_call_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .clr       (state == S_START),
    .en        (state == S_BUSY),
    .tc        (tc)
  );

  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (req_valid)          state_nxt = S_WAIT;
      S_WAIT:  if (callee_idle)        state_nxt = S_START;
      S_START:                         state_nxt = S_BUSY;
      S_BUSY:  if (callee_done || tc)  state_nxt = S_RSP;
      S_RSP:   if (rsp_ready)          state_nxt = S_IDLE;
      default:                         state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs are registered copies of the next state, so they
  // line up with the state they describe without any combinational path.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state        <= S_IDLE;
      req_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      callee_start <= 1'b0;
      rsp_data     <= '0;
      rsp_timeout  <= 1'b0;
      callee_a     <= '0;
      callee_b     <= '0;
      call_count   <= '0;
    end else begin
      state        <= state_nxt;
      req_ready    <= (state_nxt == S_IDLE);
      rsp_valid    <= (state_nxt == S_RSP);
      callee_start <= (state_nxt == S_START);

      if (accept) begin
        callee_a <= req_a;
        callee_b <= req_b;
      end

      // Done takes priority over a coincident timeout.
      if (done_hit) begin
        rsp_data    <= callee_ret;
        rsp_timeout <= 1'b0;
        call_count  <= call_count + COUNT_W'(1);
      end else if ((state == S_BUSY) && tc) begin
        rsp_data    <= '0;
        rsp_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hls_call_master.sv
// Directed bench for hls_call_master; a 4-bit-count twin shares stimulus
// so counter wrap shows up after a handful of calls.
module tb_hls_call_master;

  localparam int DATA_W = 32;
  localparam int TO_CYC = 8;

  logic              sys_clk;
  logic              sys_rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_timeout;
  logic [DATA_W-1:0] callee_a;
  logic [DATA_W-1:0] callee_b;
  logic              callee_start;
  logic              callee_idle;
  logic              callee_done;
  logic [DATA_W-1:0] callee_ret;
  logic [15:0]       call_count;

  logic              w_req_ready;
  logic              w_rsp_valid;
  logic [DATA_W-1:0] w_rsp_data;
  logic              w_rsp_timeout;
  logic [DATA_W-1:0] w_callee_a;
  logic [DATA_W-1:0] w_callee_b;
  logic              w_callee_start;
  logic [3:0]        w_call_count;

  int n_checks = 0;
  int n_errors = 0;
  int starts   = 0;

  hls_call_master #(.DATA_W(DATA_W), .TIMEOUT_CYC(TO_CYC)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_timeout(rsp_timeout), .callee_a(callee_a), .callee_b(callee_b),
    .callee_start(callee_start), .callee_idle(callee_idle),
    .callee_done(callee_done), .callee_ret(callee_ret), .call_count(call_count)
  );

  hls_call_master #(.DATA_W(DATA_W), .TIMEOUT_CYC(TO_CYC), .COUNT_W(4)) dut_w (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .req_valid(req_valid), .req_ready(w_req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(w_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(w_rsp_data),
    .rsp_timeout(w_rsp_timeout), .callee_a(w_callee_a), .callee_b(w_callee_b),
    .callee_start(w_callee_start), .callee_idle(callee_idle),
    .callee_done(callee_done), .callee_ret(callee_ret), .call_count(w_call_count)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one edge, sample just after it, and tally start pulses.
  task automatic tick();
    @(posedge sys_clk);
    #1;
    if (callee_start) starts++;
  endtask

  // One call with callee already idle; done arrives extra cycles into BUSY.
  task automatic run_call(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ret, input int extra);
    starts      = 0;
    req_a       = a;
    req_b       = b;
    req_valid   = 1'b1;
    callee_idle = 1'b1;
    tick();
    req_valid = 1'b0;
    check("acc_a", callee_a, a);
    check("acc_b", callee_b, b);
    tick();
    check("start_2nd_cycle", {31'd0, callee_start}, 32'd1);
    tick();
    repeat (extra) tick();
    callee_done = 1'b1;
    callee_ret  = ret;
    tick();
    callee_done = 1'b0;
    check("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("rsp_data", rsp_data, ret);
    check("rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
    check("start_pulses", starts, 32'd1);
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("idle_req_ready", {31'd0, req_ready}, 32'd1);
    check("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sys_rst_n   = 1'b0;
    req_valid   = 1'b0;
    req_a       = '0;
    req_b       = '0;
    rsp_ready   = 1'b0;
    callee_idle = 1'b0;
    callee_done = 1'b0;
    callee_ret  = '0;

    // Reset state
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_start", {31'd0, callee_start}, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_count", {16'd0, call_count}, 32'd0);
    check("rst_callee_a", callee_a, 32'd0);
    sys_rst_n = 1'b1;

    // Basic call: 48,18 -> ret 6, done 5 cycles after start
    run_call(32'd48, 32'd18, 32'd6, 4);
    check("basic_count", {16'd0, call_count}, 32'd1);
    consume();

    // Callee busy for 10 cycles after accept
    starts      = 0;
    req_a       = 32'd7;
    req_b       = 32'd9;
    req_valid   = 1'b1;
    callee_idle = 1'b0;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("wait_no_start", starts, 32'd0);
    callee_idle = 1'b1;
    tick();
    check("wait_start", {31'd0, callee_start}, 32'd1);
    tick();
    callee_done = 1'b1;
    callee_ret  = 32'd16;
    tick();
    callee_done = 1'b0;
    check("wait_rsp_data", rsp_data, 32'd16);
    check("wait_pulses", starts, 32'd1);
    check("wait_count", {16'd0, call_count}, 32'd2);
    consume();

    // Timeout after 8 busy cycles, then a late done is ignored
    req_a     = 32'd1;
    req_b     = 32'd2;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    repeat (TO_CYC - 1) tick();
    check("to_not_early", {31'd0, rsp_valid}, 32'd0);
    tick();
    check("to_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("to_rsp_data", rsp_data, 32'd0);
    check("to_flag", {31'd0, rsp_timeout}, 32'd1);
    check("to_count", {16'd0, call_count}, 32'd2);
    consume();
    tick();
    tick();
    callee_done = 1'b1;
    callee_ret  = 32'd99;
    tick();
    callee_done = 1'b0;
    check("late_done_count", {16'd0, call_count}, 32'd2);
    check("late_done_data", rsp_data, 32'd0);
    check("late_done_valid", {31'd0, rsp_valid}, 32'd0);
    check("late_done_ready", {31'd0, req_ready}, 32'd1);

    // Downstream stall for 6 cycles
    run_call(32'd3, 32'd4, 32'd77, 0);
    for (int i = 0; i < 6; i++) begin
      check("stall_valid", {31'd0, rsp_valid}, 32'd1);
      check("stall_data", rsp_data, 32'd77);
      check("stall_req_ready", {31'd0, req_ready}, 32'd0);
      check("stall_callee_a", callee_a, 32'd3);
      tick();
    end
    check("stall_end_req_ready", {31'd0, req_ready}, 32'd0);
    consume();
    check("stall_count", {16'd0, call_count}, 32'd3);

    // Reset in the middle of a busy call
    req_a     = 32'd5;
    req_b     = 32'd6;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    tick();
    #2 sys_rst_n = 1'b0;
    #1;
    check("mid_rst_start", {31'd0, callee_start}, 32'd0);
    check("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("mid_rst_count", {16'd0, call_count}, 32'd0);
    check("mid_rst_callee_a", callee_a, 32'd0);
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    run_call(32'd10, 32'd20, 32'd30, 0);
    check("post_rst_count", {16'd0, call_count}, 32'd1);
    consume();

    // Count wrap on the 4-bit twin: 15 more calls take it from 1 to 0
    for (int i = 0; i < 15; i++) begin
      run_call(32'(i), 32'(i + 1), 32'(i + 100), 0);
      if (i == 13) check("wrap_pre", {28'd0, w_call_count}, 32'd15);
      consume();
    end
    check("wrap_small", {28'd0, w_call_count}, 32'd0);
    check("wrap_full", {16'd0, call_count}, 32'd16);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
